// File: rtl/vproc_bm_pkg.sv
// Shared types and constants for the VProc-style burst master.
package vproc_bm_pkg;

   localparam int BURST_W = 12;

   typedef enum logic [1:0] {
      IDLE,
      WR_FETCH,
      WR_BEAT,
      RD_ISSUE
   } bm_state_e;

   function automatic int be_w(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/vproc_burst_master_if.sv
// Host stream and VProc bus signals of the burst master, grouped for port connection.
interface vproc_burst_master_if
   import vproc_bm_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 64
);
   localparam int BE_W = be_w(DATA_WIDTH);

   logic                  CmdValid;
   logic                  CmdReady;
   logic [ADDR_WIDTH-1:0] CmdAddr;
   logic                  CmdWrite;
   logic [BURST_W-1:0]    CmdBurst;
   logic [2*BE_W-1:0]     CmdBE;

   logic                  WrValid;
   logic                  WrReady;
   logic [DATA_WIDTH-1:0] WrData;

   logic                  RdValid;
   logic                  RdReady;
   logic [DATA_WIDTH-1:0] RdData;
   logic                  RdLast;

   logic [ADDR_WIDTH-1:0] Addr;
   logic [BE_W-1:0]       BE;
   logic                  WE;
   logic                  RD;
   logic [DATA_WIDTH-1:0] DataOut;
   logic [DATA_WIDTH-1:0] DataIn;
   logic                  WRAck;
   logic                  RDAck;
   logic                  BurstFirst;
   logic                  BurstLast;

   modport master (
      input  CmdValid, CmdAddr, CmdWrite, CmdBurst, CmdBE,
      input  WrValid, WrData, RdReady, DataIn, WRAck, RDAck,
      output CmdReady, WrReady, RdValid, RdData, RdLast,
      output Addr, BE, WE, RD, DataOut, BurstFirst, BurstLast
   );

   modport slave (
      output CmdValid, CmdAddr, CmdWrite, CmdBurst, CmdBE,
      output WrValid, WrData, RdReady, DataIn, WRAck, RDAck,
      input  CmdReady, WrReady, RdValid, RdData, RdLast,
      input  Addr, BE, WE, RD, DataOut, BurstFirst, BurstLast
   );

endinterface

// File: rtl/vproc_sync_fifo.sv
// Single-clock FIFO with occupancy count; pop data reads as zero while empty.
module vproc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/vproc_burst_master.sv
// Synthesisable VProc-style burst master: host command/write stream in, bus beats out,
// read data returned through a buffered backpressured stream.
//
// state    | meaning
// IDLE     | CmdReady high, waiting for a command
// WR_FETCH | WrReady high, waiting for the next write word
// WR_BEAT  | WE held with Addr/BE/DataOut until WRAck
// RD_ISSUE | RD raised whenever the read buffer can take the beat
module vproc_burst_master
   import vproc_bm_pkg::*;
#(
   parameter int DATA_WIDTH      = 64,
   parameter int ADDR_WIDTH      = 64,
   parameter int BURST_ADDR_INCR = 1,
   parameter int RD_FIFO_DEPTH   = 8
) (
   input logic                  Clk,
   input logic                  nReset,
   vproc_burst_master_if.master bus
);
   localparam int BE_W = be_w(DATA_WIDTH);
   localparam int CW   = $clog2(RD_FIFO_DEPTH) + 1;
   localparam logic [ADDR_WIDTH-1:0] INCR = ADDR_WIDTH'(BURST_ADDR_INCR);

   bm_state_e          state;
   logic [BURST_W-1:0] remaining;
   logic [BURST_W-1:0] burst_eff;
   logic [BE_W-1:0]    be_first;
   logic [BE_W-1:0]    be_last;

   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_empty;
   logic [CW-1:0]      fifo_count;
   logic [CW-1:0]      count_nxt;
   logic               space_nxt;
   logic [DATA_WIDTH:0] fifo_out;

   assign burst_eff = (bus.CmdBurst == '0) ? BURST_W'(1) : bus.CmdBurst;

   assign fifo_push = (state == RD_ISSUE) & bus.RD & bus.RDAck;
   assign fifo_pop  = ~fifo_empty & bus.RdReady;
   // RD is registered, so space is judged on the occupancy after this edge.
   assign count_nxt = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
   assign space_nxt = (count_nxt < CW'(RD_FIFO_DEPTH));

   assign bus.RdValid = ~fifo_empty;
   assign bus.RdData  = fifo_out[DATA_WIDTH:1];
   assign bus.RdLast  = fifo_out[0];

   // A word offered in the ack cycle of a non-final beat feeds the next beat directly.
   assign bus.WrReady = (state == WR_FETCH) |
                        ((state == WR_BEAT) & bus.WRAck & (remaining != BURST_W'(1)));

   vproc_sync_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (RD_FIFO_DEPTH)
   ) u_rd_fifo (
      .clk       (Clk),
      .rst_n     (nReset),
      .push      (fifo_push),
      .push_data ({bus.DataIn, remaining == BURST_W'(1)}),
      .pop       (fifo_pop),
      .pop_data  (fifo_out),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state          <= IDLE;
         remaining      <= '0;
         be_first       <= '0;
         be_last        <= '0;
         bus.CmdReady   <= 1'b1;
         bus.WE         <= 1'b0;
         bus.RD         <= 1'b0;
         bus.Addr       <= '0;
         bus.BE         <= '0;
         bus.DataOut    <= '0;
         bus.BurstFirst <= 1'b0;
         bus.BurstLast  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.CmdValid) begin
                  bus.CmdReady   <= 1'b0;
                  bus.Addr       <= bus.CmdAddr;
                  remaining      <= burst_eff;
                  be_first       <= bus.CmdBE[BE_W-1:0];
                  be_last        <= bus.CmdBE[2*BE_W-1:BE_W];
                  bus.BE         <= bus.CmdBE[BE_W-1:0];
                  bus.BurstFirst <= 1'b1;
                  bus.BurstLast  <= (burst_eff == BURST_W'(1));
                  if (bus.CmdWrite) begin
                     state <= WR_FETCH;
                  end else begin
                     state  <= RD_ISSUE;
                     bus.RD <= space_nxt;
                  end
               end
            end

            WR_FETCH: begin
               if (bus.WrValid) begin
                  bus.DataOut <= bus.WrData;
                  bus.WE      <= 1'b1;
                  state       <= WR_BEAT;
               end
            end

            WR_BEAT: begin
               if (bus.WRAck) begin
                  remaining <= remaining - BURST_W'(1);
                  if (remaining == BURST_W'(1)) begin
                     state          <= IDLE;
                     bus.WE         <= 1'b0;
                     bus.CmdReady   <= 1'b1;
                     bus.BurstFirst <= 1'b0;
                     bus.BurstLast  <= 1'b0;
                  end else begin
                     bus.Addr       <= bus.Addr + INCR;
                     bus.BurstFirst <= 1'b0;
                     bus.BurstLast  <= (remaining == BURST_W'(2));
                     bus.BE         <= (remaining == BURST_W'(2)) ? be_last : '1;
                     if (bus.WrValid) begin
                        bus.DataOut <= bus.WrData;
                     end else begin
                        bus.WE <= 1'b0;
                        state  <= WR_FETCH;
                     end
                  end
               end
            end

            RD_ISSUE: begin
               if (bus.RD && bus.RDAck) begin
                  remaining <= remaining - BURST_W'(1);
                  if (remaining == BURST_W'(1)) begin
                     state          <= IDLE;
                     bus.RD         <= 1'b0;
                     bus.CmdReady   <= 1'b1;
                     bus.BurstFirst <= 1'b0;
                     bus.BurstLast  <= 1'b0;
                  end else begin
                     bus.Addr       <= bus.Addr + INCR;
                     bus.BurstFirst <= 1'b0;
                     bus.BurstLast  <= (remaining == BURST_W'(2));
                     bus.BE         <= (remaining == BURST_W'(2)) ? be_last : '1;
                     bus.RD         <= space_nxt;
                  end
               end else begin
                  bus.RD <= space_nxt;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vproc_burst_master.sv
// Scoreboard bench for vproc_burst_master: a burst-level model queues expected bus beats
// and read returns; a monitor compares them as the DUT presents them.
module tb_vproc_burst_master;
   import vproc_bm_pkg::*;

   localparam int DW    = 64;
   localparam int AW    = 64;
   localparam int INCR  = 1;
   localparam int DEPTH = 8;
   localparam int BEW   = DW / 8;

   logic Clk = 1'b0;
   logic nReset = 1'b1;
   always #5 Clk = ~Clk;

   vproc_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   vproc_burst_master #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_ADDR_INCR(INCR), .RD_FIFO_DEPTH(DEPTH)
   ) dut (
      .Clk    (Clk),
      .nReset (nReset),
      .bus    (bus)
   );

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [BEW-1:0] be;
      logic          first;
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } rd_t;

   beat_t         exp_beat[$];
   rd_t           rd_exp[$];
   logic [DW-1:0] wr_q[$];
   logic [DW-1:0] wr_later[$];
   logic [DW-1:0] rd_resp_q[$];
   logic [DW-1:0] issued_data[$];

   int checks = 0;
   int failures = 0;
   int ack_pct = 100;
   int wrv_pct = 100;
   int rdr_pct = 100;
   int occ = 0;
   int rd_acks = 0;
   int wr_acks = 0;

   task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Model: a burst expands into its beat list from the address/BE rules alone.
   task automatic issue(input logic [AW-1:0] addr, input logic wr, input int burst,
                        input logic [2*BEW-1:0] be, input int push_n);
      int n;
      int t;
      beat_t b;
      rd_t r;
      logic [DW-1:0] d;
      n = (burst == 0) ? 1 : burst;
      issued_data.delete();
      for (int i = 0; i < n; i++) begin
         d = {$urandom, $urandom};
         issued_data.push_back(d);
         b.we    = wr;
         b.addr  = addr + AW'(i * INCR);
         b.first = (i == 0);
         b.last  = (i == n - 1);
         b.be    = (i == 0) ? be[BEW-1:0] : (i == n - 1) ? be[2*BEW-1:BEW] : '1;
         b.data  = wr ? d : '0;
         exp_beat.push_back(b);
         if (wr) begin
            if (i < push_n) wr_q.push_back(d);
            else wr_later.push_back(d);
         end else begin
            rd_resp_q.push_back(d);
            r.data = d;
            r.last = (i == n - 1);
            rd_exp.push_back(r);
         end
      end
      @(posedge Clk); #1;
      bus.CmdValid = 1'b1;
      bus.CmdAddr  = addr;
      bus.CmdWrite = wr;
      bus.CmdBurst = 12'(burst);
      bus.CmdBE    = be;
      t = 0;
      do begin
         @(negedge Clk);
         t++;
      end while (bus.CmdReady !== 1'b1 && t < 5000);
      check_eq("cmd_accept", bus.CmdReady, 1);
      @(posedge Clk); #1;
      bus.CmdValid = 1'b0;
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (!(exp_beat.size() == 0 && rd_exp.size() == 0 && bus.CmdReady === 1'b1) && t < 20000) begin
         @(posedge Clk); #2;
         t++;
      end
      checks++;
      if (t >= 20000) begin
         failures++;
         $display("FAIL %s drain actual beats=%0d reads=%0d required 0", name, exp_beat.size(), rd_exp.size());
      end
   endtask

   // Bus slave and stream partners: random acks (regardless of strobe), valids and readies.
   initial begin
      forever begin
         @(posedge Clk); #1;
         bus.WRAck   = ($urandom_range(99) < ack_pct);
         bus.RDAck   = ($urandom_range(99) < ack_pct);
         bus.DataIn  = (rd_resp_q.size() > 0) ? rd_resp_q[0] : {$urandom, $urandom};
         bus.WrValid = (wr_q.size() > 0) && ($urandom_range(99) < wrv_pct);
         bus.WrData  = (wr_q.size() > 0) ? wr_q[0] : '0;
         bus.RdReady = ($urandom_range(99) < rdr_pct);
      end
   end

   initial begin
      bit    prev_hs;
      beat_t b;
      rd_t   r;
      prev_hs = 1'b0;
      forever begin
         @(negedge Clk);
         if (!nReset) begin
            occ     = 0;
            prev_hs = 1'b0;
         end else begin
            if (prev_hs) check_eq("wr_latency", bus.WE, 1);
            check_eq("rd_valid", bus.RdValid, occ > 0);
            if (bus.RD) check_eq("rd_space", occ < DEPTH, 1);
            if (bus.WE || bus.RD) begin
               if (exp_beat.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL beat_unexpected actual=strobe addr %0h required=no beat", bus.Addr);
               end else begin
                  b = exp_beat[0];
                  check_eq("beat_dir", bus.WE, b.we);
                  check_eq("beat_addr", bus.Addr, b.addr);
                  check_eq("beat_be", bus.BE, b.be);
                  check_eq("beat_first", bus.BurstFirst, b.first);
                  check_eq("beat_last", bus.BurstLast, b.last);
                  if (b.we) check_eq("beat_data", bus.DataOut, b.data);
                  if ((bus.WE && bus.WRAck) || (bus.RD && bus.RDAck)) void'(exp_beat.pop_front());
               end
            end
            if (bus.WE && bus.WRAck) wr_acks++;
            if (bus.RD && bus.RDAck) begin
               rd_acks++;
               if (rd_resp_q.size() > 0) void'(rd_resp_q.pop_front());
            end
            prev_hs = bus.WrValid && bus.WrReady;
            if (prev_hs && wr_q.size() > 0) void'(wr_q.pop_front());
            if (bus.RdValid && bus.RdReady) begin
               if (rd_exp.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL rd_unexpected actual=word %0h required=no word", bus.RdData);
               end else begin
                  r = rd_exp.pop_front();
                  check_eq("rd_data", bus.RdData, r.data);
                  check_eq("rd_last", bus.RdLast, r.last);
               end
            end
            occ = occ + ((bus.RD && bus.RDAck) ? 1 : 0) - ((bus.RdValid && bus.RdReady) ? 1 : 0);
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog actual=time limit reached required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int base;
      logic [15:0] be_r;
      logic [DW-1:0] d1;
      bus.CmdValid = 1'b0;
      bus.CmdAddr  = '0;
      bus.CmdWrite = 1'b0;
      bus.CmdBurst = '0;
      bus.CmdBE    = '0;
      bus.WrValid  = 1'b0;
      bus.WrData   = '0;
      bus.RdReady  = 1'b0;
      bus.DataIn   = '0;
      bus.WRAck    = 1'b0;
      bus.RDAck    = 1'b0;
      #2 nReset = 1'b0;
      repeat (3) @(posedge Clk);
      #2;
      check_eq("rst_cmdready", bus.CmdReady, 1);
      check_eq("rst_we", bus.WE, 0);
      check_eq("rst_rd", bus.RD, 0);
      check_eq("rst_wrready", bus.WrReady, 0);
      check_eq("rst_first", bus.BurstFirst, 0);
      check_eq("rst_last", bus.BurstLast, 0);
      check_eq("rst_addr", bus.Addr, 0);
      check_eq("rst_be", bus.BE, 0);
      check_eq("rst_dataout", bus.DataOut, 0);
      check_eq("rst_rdvalid", bus.RdValid, 0);
      check_eq("rst_rddata", bus.RdData, 0);
      check_eq("rst_rdlast", bus.RdLast, 0);
      nReset = 1'b1;

      // 4-beat write, BE 0x0F first / 0xF0 last, acks every cycle
      issue(64'h100, 1'b1, 4, 16'hF00F, 4);
      drain("wr4");

      // 3-beat write with the third word withheld for 5 cycles
      base = wr_acks;
      issue(64'h200, 1'b1, 3, 16'hC03F, 2);
      d1 = issued_data[1];
      t = 0;
      while (!(wr_acks >= base + 2 && bus.WE == 1'b0) && t < 500) begin
         @(posedge Clk); #2;
         t++;
      end
      check_eq("gap_reached", wr_acks - base, 2);
      for (int i = 0; i < 5; i++) begin
         @(posedge Clk); #2;
         check_eq("gap_we", bus.WE, 0);
         check_eq("gap_addr", bus.Addr, 64'h202);
         check_eq("gap_dataout", bus.DataOut, d1);
      end
      wr_q.push_back(wr_later.pop_front());
      drain("wr_gap");

      // 12-beat read into an 8-deep buffer with no consumer
      rdr_pct = 0;
      base = rd_acks;
      issue(64'h300, 1'b0, 12, 16'h8001, 0);
      t = 0;
      while (rd_acks < base + 8 && t < 500) begin
         @(posedge Clk); #2;
         t++;
      end
      repeat (10) @(posedge Clk);
      #2;
      check_eq("stall_acks", rd_acks - base, 8);
      check_eq("stall_rd", bus.RD, 0);
      check_eq("stall_rdvalid", bus.RdValid, 1);
      rdr_pct = 100;
      drain("rd12");

      // zero-length read at all-ones, then a 2-beat read wrapping to 0
      rdr_pct = 70;
      issue({AW{1'b1}}, 1'b0, 0, 16'h0301, 0);
      issue({AW{1'b1}}, 1'b0, 2, 16'h0703, 0);
      drain("wrap");

      // randomized traffic
      for (int k = 0; k < 25; k++) begin
         ack_pct = $urandom_range(100, 20);
         wrv_pct = $urandom_range(100, 20);
         rdr_pct = $urandom_range(100, 20);
         be_r = 16'($urandom);
         issue(($urandom_range(3) == 0) ? {AW{1'b1}} - AW'($urandom_range(3)) : {$urandom, $urandom},
               1'($urandom), ($urandom_range(7) == 0) ? 12 : int'($urandom_range(6)), be_r, 12);
      end
      drain("random");

      // reset in the middle of a write with buffered read data pending
      ack_pct = 100;
      wrv_pct = 100;
      rdr_pct = 0;
      base = rd_acks;
      issue(64'h400, 1'b0, 3, 16'hFFFF, 0);
      t = 0;
      while (rd_acks < base + 3 && t < 500) begin
         @(posedge Clk); #2;
         t++;
      end
      ack_pct = 40;
      base = wr_acks;
      issue(64'h500, 1'b1, 4, 16'h1F0F, 4);
      t = 0;
      while (wr_acks < base + 2 && t < 500) begin
         @(posedge Clk); #2;
         t++;
      end
      check_eq("mid_reached", wr_acks - base, 2);
      nReset = 1'b0;
      #1;
      check_eq("mid_we", bus.WE, 0);
      check_eq("mid_rd", bus.RD, 0);
      check_eq("mid_first", bus.BurstFirst, 0);
      check_eq("mid_last", bus.BurstLast, 0);
      check_eq("mid_cmdready", bus.CmdReady, 1);
      check_eq("mid_rdvalid", bus.RdValid, 0);
      check_eq("mid_rddata", bus.RdData, 0);
      exp_beat.delete();
      rd_exp.delete();
      wr_q.delete();
      wr_later.delete();
      rd_resp_q.delete();
      repeat (2) @(posedge Clk);
      #2 nReset = 1'b1;
      ack_pct = 100;
      rdr_pct = 100;
      issue(64'h600, 1'b1, 2, 16'hF00F, 2);
      issue(64'h700, 1'b0, 2, 16'h0FF0, 0);
      drain("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vproc_burst_master.md
Name: vproc_burst_master

Overview:
Parametrised-width successor to the 64-bit VProc bus master. It takes burst commands and write data from a host-side valid/ready stream, drives the VProc-style bus (Addr/BE/WE/RD/DataOut, WRAck/RDAck, BurstFirst/BurstLast), and returns read data through a backpressured, buffered stream. Unlike the PLI-driven master, it is synthesisable RTL, stalls on missing write data or a full read buffer, and supports any power-of-two data width.

Parameters:
DATA_WIDTH, 64, bus data width; power of two, 32..512; BE_W = DATA_WIDTH/8.
ADDR_WIDTH, 64, address width.
BURST_ADDR_INCR, 1, Addr increment per beat, modulo 2^ADDR_WIDTH.
RD_FIFO_DEPTH, 8, read-return buffer entries; power of two, >= 2.

Ports:
Clk  in  1  sole clock, rising edge.
nReset  in  1  asynchronous active-low reset.
CmdValid  in  1  command valid.
CmdReady  out  1  command accepted when CmdValid & CmdReady.
CmdAddr  in  ADDR_WIDTH  start address.
CmdWrite  in  1  1 = write burst, 0 = read burst.
CmdBurst  in  12  beat count; 0 is treated as 1.
CmdBE  in  2*BE_W  [BE_W-1:0] = first-beat BE; upper half = last-beat BE.
WrValid  in  1  write data valid.
WrReady  out  1  write data accepted when WrValid & WrReady.
WrData  in  DATA_WIDTH  write data.
RdValid  out  1  read data available.
RdReady  in  1  read data consumed when RdValid & RdReady.
RdData  out  DATA_WIDTH  read data.
RdLast  out  1  marks the final beat of a read burst.
Addr  out  ADDR_WIDTH  bus address.
BE  out  BE_W  bus byte enables.
WE  out  1  write strobe.
RD  out  1  read strobe.
DataOut  out  DATA_WIDTH  bus write data.
DataIn  in  DATA_WIDTH  bus read data, sampled when RD & RDAck.
WRAck  in  1  write beat complete.
RDAck  in  1  read beat complete.
BurstFirst  out  1  high during the first beat of a burst.
BurstLast  out  1  high during the final beat of a burst.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; CmdReady=1; WE=RD=0; WrReady=0; BurstFirst=BurstLast=0; Addr, BE, DataOut = 0; FIFO empty (RdValid=0, RdData=0, RdLast=0). Reset mid-burst abandons the burst; no partial completion.
- FSM states:
  - IDLE: CmdReady=1. On accept, latch address, count (0 becomes 1), first BE and last BE. Write commands go to WR_FETCH; reads go to RD_ISSUE.
  - WR_FETCH: WrReady=1, WE=0. On WrValid, load DataOut and assert WE next edge; go to WR_BEAT. No cycle limit on waiting.
  - WR_BEAT: WE held with Addr/BE/DataOut stable until a cycle with WRAck=1. Then decrement remaining. Remaining 0: go to IDLE with WE=0 on the same edge. Otherwise, Addr += BURST_ADDR_INCR. If WrValid is also presented in the ack cycle (WrReady=1 during WR_BEAT), the next beat follows back-to-back with WE staying 1; otherwise go to WR_FETCH.
  - RD_ISSUE: RD asserted only while FIFO occupancy plus outstanding beats (0 or 1) < RD_FIFO_DEPTH; else RD=0 (stall). On RD & RDAck, push {DataIn, remaining==1} into the FIFO, decrement remaining and increment Addr. Remaining 0: go to IDLE with RD=0. Back-to-back beats with RD held at 1 are allowed while space remains.
- BE rules: single-beat burst uses the first BE. Multi-beat: first beat uses the first BE, middle beats all-ones, final beat uses the last BE.
- BurstFirst is high for the whole first beat, including its WE/RD hold. BurstLast is high for the whole final beat. For a single-beat burst both are high.
- CmdReady=1 only in IDLE. The next command is accepted earliest one cycle after the final ack, so there is one idle bus cycle between bursts.
- Read FIFO: push and pop in the same cycle are legal; occupancy is unchanged. FIFO contents persist across later commands. RdLast travels with its data word.
- Acks are ignored when the matching strobe is low. WRAck during a read and RDAck during a write are ignored.
- Address wraps modulo 2^ADDR_WIDTH with no error.
- Write latency: WrValid accepted -> WE high at the next edge. Read latency: RDAck -> RdValid high at the next edge.

Decomposition:
Package vproc_bm_pkg holds the state enum (IDLE, WR_FETCH, WR_BEAT, RD_ISSUE), the burst-count width constant (12) and the BE_W function. Sub-module vproc_sync_fifo (parametrised width/depth, async active-low reset, count output) implements the read buffer.

Test Plan:
- Write, CmdBurst=4, Addr=0x100, CmdBE first=0x0F/last=0xF0 (DATA_WIDTH=64), WRAck every cycle -> Addr 0x100..0x103; BE 0x0F, 0xFF, 0xFF, 0xF0; BurstFirst on beat 0 only, BurstLast on beat 3 only.
- Write, CmdBurst=3, WrValid dropped for 5 cycles before beat 2 -> WE low for those cycles, Addr and DataOut unchanged, beat 2 data correct after WrValid resumes.
- Read, CmdBurst=12, RD_FIFO_DEPTH=8, RdReady=0 -> RD deasserts after 8 acks. Raising RdReady resumes RD; 12 words delivered in order, RdLast only on the 12th.
- CmdBurst=0 read, Addr=all-ones, BURST_ADDR_INCR=1 -> exactly one beat with BurstFirst=BurstLast=1. A following 2-beat burst from all-ones wraps Addr to 0.
- nReset asserted mid-way through a 4-beat write after beat 1 -> WE/RD/BurstFirst/BurstLast low immediately, CmdReady=1, FIFO empty. A fresh command after release completes normally.
